// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the cascaded modulo counter: control state encoding,
// width helper and the per-digit wrap test used by the digits and the top.
package fsm_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } ctrl_state_t;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // A digit sits at its wrap value when the next step in this direction rolls it over.
    function automatic logic at_wrap(input logic [31:0] q, input logic up_dn, input int mod);
        return up_dn ? (q == 32'(mod - 1)) : (q == 32'd0);
    endfunction

endpackage

// File: rtl/fsm_counter_digit.sv
// One mod-MOD digit of the cascade: clear, load and step with carry/borrow out.
// Out-of-range content (>= MOD) is forced to zero on load and on the next step.
module fsm_counter_digit
    import fsm_counter_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ci,
    input  logic         up_dn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         co
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic [W-1:0] step_v;
    logic [W-1:0] load_v;

    always_comb begin
        step_v = '0;
        if (q > MAXV) begin
            step_v = '0;
        end else if (up_dn) begin
            step_v = (q == MAXV) ? '0 : q + W'(1);
        end else begin
            step_v = (q == '0) ? MAXV : q - W'(1);
        end
    end

    assign load_v = (d > MAXV) ? '0 : d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_v;
        end else if (ci) begin
            q <= step_v;
        end
    end

    assign co = ci & at_wrap(32'(q), up_dn, MOD);

endmodule

// File: rtl/fsm_counter_cascade.sv
// Multi-digit up/down modulo counter with load/clear, free-run or one-shot mode,
// combinational ripple terminal count and registered carry/borrow and done flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | counting; steps on each enabled edge, tc may assert
// ST_DONE | one-shot run finished; count frozen until clr, load or reset
module fsm_counter_cascade
    import fsm_counter_pkg::*;
#(
    parameter  int MOD    = 10,
    parameter  int DIGITS = 4,
    localparam int W      = clog2(MOD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic                oneshot,
    input  logic [DIGITS*W-1:0] load_val,
    output logic [DIGITS*W-1:0] cnt,
    output logic                tc,
    output logic                cout,
    output logic                done
);

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] wrap;
    logic              terminal;
    logic              running;

    assign running  = (state_q == ST_RUN);
    assign terminal = &wrap;

    // A one-shot step at the terminal value must leave the count untouched.
    assign carry[0] = en & running & ~(oneshot & terminal);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        fsm_counter_digit #(
            .MOD (MOD),
            .W   (W)
        ) u_digit (
            .clk   (clk),
            .rst   (rst),
            .ci    (carry[i]),
            .up_dn (up_dn),
            .clr   (clr),
            .load  (load),
            .d     (load_val[i*W +: W]),
            .q     (cnt[i*W +: W]),
            .co    (carry[i+1])
        );

        assign wrap[i] = at_wrap(32'(cnt[i*W +: W]), up_dn, MOD);
    end

    assign tc = rst & en & ~clr & ~load & running & terminal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr || load) begin
            state_d = ST_RUN;
        end else if (tc && oneshot) begin
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cout <= 1'b0;
        end else begin
            cout <= tc;
        end
    end

    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fsm_counter_cascade.sv
// Directed bench for the cascaded counter: BCD 2-digit instance plus a
// 3-digit hex instance for the wrap at 0xFFF.
module tb_fsm_counter_cascade;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic        oneshot;
    logic [7:0]  load_val;
    logic [7:0]  cnt;
    logic        tc;
    logic        cout;
    logic        done;

    logic        en16;
    logic        clr16;
    logic        load16;
    logic [11:0] load_val16;
    logic [11:0] cnt16;
    logic        tc16;
    logic        cout16;
    logic        done16;

    int n_tests;
    int n_fail;

    fsm_counter_cascade #(.MOD(10), .DIGITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .oneshot  (oneshot),
        .load_val (load_val),
        .cnt      (cnt),
        .tc       (tc),
        .cout     (cout),
        .done     (done)
    );

    fsm_counter_cascade #(.MOD(16), .DIGITS(3)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .en       (en16),
        .up_dn    (up_dn),
        .clr      (clr16),
        .load     (load16),
        .oneshot  (1'b0),
        .load_val (load_val16),
        .cnt      (cnt16),
        .tc       (tc16),
        .cout     (cout16),
        .done     (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        en         = 1'b1;
        up_dn      = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
        oneshot    = 1'b0;
        load_val   = '0;
        en16       = 1'b0;
        clr16      = 1'b0;
        load16     = 1'b0;
        load_val16 = '0;

        // Reset: down at 0x00 is terminal, so tc proves the reset gating.
        #12;
        chk("rst_cnt", 32'(cnt), 32'h00);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tc", 32'(tc), 32'h0);
        chk("rst_done16", 32'(done16), 32'h0);

        // Case 1: up free-run through 0x99 and wrap.
        up_dn = 1'b1;
        en    = 1'b1;
        rst   = 1'b1;
        repeat (9) tick();
        chk("up_09", 32'(cnt), 32'h09);
        tick();
        chk("up_10", 32'(cnt), 32'h10);
        repeat (89) tick();
        chk("up_99", 32'(cnt), 32'h99);
        chk("up_99_tc", 32'(tc), 32'h1);
        chk("up_99_cout", 32'(cout), 32'h0);
        tick();
        chk("up_wrap", 32'(cnt), 32'h00);
        chk("up_wrap_cout", 32'(cout), 32'h1);
        chk("up_wrap_tc", 32'(tc), 32'h0);
        tick();
        chk("up_01", 32'(cnt), 32'h01);
        chk("up_01_cout", 32'(cout), 32'h0);

        // Case 2: down from 0x00 borrows to 0x99.
        clr = 1'b1;
        en  = 1'b0;
        tick();
        chk("clr_cnt", 32'(cnt), 32'h00);
        clr   = 1'b0;
        up_dn = 1'b0;
        en    = 1'b1;
        #1;
        chk("dn_00_tc", 32'(tc), 32'h1);
        tick();
        chk("dn_wrap", 32'(cnt), 32'h99);
        chk("dn_wrap_cout", 32'(cout), 32'h1);
        tick();
        chk("dn_98", 32'(cnt), 32'h98);
        chk("dn_98_cout", 32'(cout), 32'h0);

        // Case 3: load, sanitised load, clear beats load.
        load     = 1'b1;
        load_val = 8'h37;
        tick();
        chk("ld_37", 32'(cnt), 32'h37);
        chk("ld_37_cout", 32'(cout), 32'h0);
        load_val = 8'hA5;
        tick();
        chk("ld_a5", 32'(cnt), 32'h05);
        clr      = 1'b1;
        load_val = 8'h37;
        tick();
        chk("clr_over_ld", 32'(cnt), 32'h00);
        clr  = 1'b0;
        load = 1'b0;
        en   = 1'b0;

        // Case 4: one-shot up stops at 0x99.
        oneshot  = 1'b1;
        up_dn    = 1'b1;
        load     = 1'b1;
        load_val = 8'h97;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        chk("os_98", 32'(cnt), 32'h98);
        tick();
        chk("os_99", 32'(cnt), 32'h99);
        chk("os_99_tc", 32'(tc), 32'h1);
        tick();
        chk("os_hold", 32'(cnt), 32'h99);
        chk("os_done", 32'(done), 32'h1);
        chk("os_cout", 32'(cout), 32'h1);
        chk("os_done_tc", 32'(tc), 32'h0);
        tick();
        chk("os_frozen", 32'(cnt), 32'h99);
        chk("os_cout_low", 32'(cout), 32'h0);
        chk("os_done_stays", 32'(done), 32'h1);
        clr = 1'b1;
        tick();
        chk("os_clr_cnt", 32'(cnt), 32'h00);
        chk("os_clr_done", 32'(done), 32'h0);
        clr     = 1'b0;
        oneshot = 1'b0;
        en      = 1'b0;

        // Case 5: hold at 0x19, then carry into digit 1.
        load     = 1'b1;
        load_val = 8'h19;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_cnt", 32'(cnt), 32'h19);
            chk("hold_tc", 32'(tc), 32'h0);
        end
        en = 1'b1;
        tick();
        chk("carry_20", 32'(cnt), 32'h20);
        chk("carry_cout", 32'(cout), 32'h0);

        // Case 6a: async reset between edges at 0x45.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h40;
        tick();
        load = 1'b0;
        en   = 1'b1;
        repeat (5) tick();
        chk("pre_rst_45", 32'(cnt), 32'h45);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt), 32'h00);
        chk("arst_cout", 32'(cout), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_tc", 32'(tc), 32'h0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_01", 32'(cnt), 32'h01);

        // Case 6b: async reset while done and cout are high.
        oneshot  = 1'b1;
        load     = 1'b1;
        load_val = 8'h99;
        tick();
        load = 1'b0;
        tick();
        chk("pre_rst_done", 32'(done), 32'h1);
        chk("pre_rst_cout", 32'(cout), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst2_done", 32'(done), 32'h0);
        chk("arst2_cout", 32'(cout), 32'h0);
        chk("arst2_cnt", 32'(cnt), 32'h00);
        #2;
        rst     = 1'b1;
        oneshot = 1'b0;
        en      = 1'b0;

        // Hex instance, three digits: up free-run wraps at 0xFFF.
        en16  = 1'b1;
        up_dn = 1'b1;
        repeat (256) tick();
        chk("h16_100", 32'(cnt16), 32'h100);
        repeat (3839) tick();
        chk("h16_fff", 32'(cnt16), 32'hFFF);
        chk("h16_fff_tc", 32'(tc16), 32'h1);
        tick();
        chk("h16_wrap", 32'(cnt16), 32'h000);
        chk("h16_wrap_cout", 32'(cout16), 32'h1);
        tick();
        chk("h16_001", 32'(cnt16), 32'h001);
        chk("h16_001_cout", 32'(cout16), 32'h0);
        en16 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
